// File: rtl/disaggregator_pkg.sv
// Shared stream package: lane-index sizing, width-field sizing, the
// fetch-width clamp and the holding-register state encoding used by the
// aggregator/disaggregator pair.
package disaggregator_pkg;

  // Largest lane count any stream block supports.
  localparam int MAX_FETCH_WIDTH = 16;

  // Width of a lane-count field able to hold MAX_FETCH_WIDTH itself.
  localparam int FW_MAX_W = $clog2(MAX_FETCH_WIDTH) + 1;

  // Holding register is either empty or emitting lanes of a loaded word.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_EMIT  = 1'b1
  } disagg_state_e;

  // Bits needed to index lanes 0..fetch_width-1.
  function automatic int lane_idx_width(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 1;
  endfunction

  // Bits needed to hold a lane count 1..fetch_width (inclusive).
  function automatic int fw_field_width(input int fetch_width);
    return $clog2(fetch_width) + 1;
  endfunction

  // A request of zero lanes or more lanes than the hardware has means "all".
  function automatic logic [FW_MAX_W-1:0] clamp_fetch_width(
    input logic [FW_MAX_W-1:0] req_fw,
    input logic [FW_MAX_W-1:0] max_fw
  );
    logic [FW_MAX_W-1:0] res;
    if ((req_fw == {FW_MAX_W{1'b0}}) || (req_fw > max_fw)) begin
      res = max_fw;
    end else begin
      res = req_fw;
    end
    return res;
  endfunction

endpackage

// File: rtl/disaggregator.sv
// Disaggregator: splits one wide FWFT word into up to FETCH_WIDTH narrow
// words, emitted lane 0 first. The active lane count can be changed at
// run time; a change only takes effect between words.
module disaggregator
  import disaggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [$clog2(FETCH_WIDTH):0]      input_fetch_width,
  output logic                              busy
);

  localparam int IDX_W = lane_idx_width(FETCH_WIDTH);
  localparam int FW_W  = fw_field_width(FETCH_WIDTH);

  localparam logic [FW_W-1:0]     FW_FULL     = FW_W'(FETCH_WIDTH);
  localparam logic [FW_MAX_W-1:0] FW_FULL_EXT = FW_MAX_W'(FETCH_WIDTH);

  // Holding register state
  disagg_state_e                      state_q;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0]  hold_q;
  logic [IDX_W-1:0]                   index_q;

  // Lane-count state
  logic [FW_W-1:0]                    fw_q;
  logic                               pending_q;
  logic [FW_W-1:0]                    pending_fw_q;

  // Handshake and control terms
  logic                               valid_s;
  logic                               last_lane_s;
  logic                               enq_s;
  logic                               word_done_s;
  logic                               change_active_s;
  logic                               apply_s;
  logic                               deq_s;
  logic [FW_W-1:0]                    change_fw_s;
  logic [FW_W-1:0]                    req_fw_s;

  assign valid_s = (state_q == ST_EMIT);

  // Resolve which lane count is being asked for this cycle: a fresh request
  // overrides one already waiting.
  always_comb begin
    change_fw_s = FW_W'(clamp_fetch_width(FW_MAX_W'(input_fetch_width), FW_FULL_EXT));
    if (change_fetch_width) begin
      req_fw_s = change_fw_s;
    end else begin
      req_fw_s = pending_fw_q;
    end
  end

  // Handshake decode. A width request (new or waiting) blocks the pop so the
  // next word is always loaded under the new lane count; reset blocks both
  // sides so no lane leaks out while the block is being cleared.
  always_comb begin
    last_lane_s     = (FW_W'(index_q) == (fw_q - FW_W'(1)));
    enq_s           = valid_s & receiver_full_n & ~rst;
    word_done_s     = enq_s & last_lane_s;
    change_active_s = change_fetch_width | pending_q;
    apply_s         = change_active_s & (~valid_s | word_done_s);
    deq_s           = ~rst & sender_empty_n & ~change_active_s & (~valid_s | word_done_s);
  end

  assign sender_deq    = deq_s;
  assign receiver_enq  = enq_s;
  assign receiver_data = hold_q[index_q*DATA_WIDTH +: DATA_WIDTH];
  assign busy          = valid_s | pending_q;

  // Holding-register FSM: load on pop, step the lane index on each enq,
  // fall back to EMPTY after the last active lane unless reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      index_q <= {IDX_W{1'b0}};
      hold_q  <= {(FETCH_WIDTH*DATA_WIDTH){1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (deq_s) begin
            hold_q  <= sender_data;
            index_q <= {IDX_W{1'b0}};
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (deq_s) begin
            hold_q  <= sender_data;
            index_q <= {IDX_W{1'b0}};
            state_q <= ST_EMIT;
          end else if (word_done_s) begin
            index_q <= {IDX_W{1'b0}};
            state_q <= ST_EMPTY;
          end else if (enq_s) begin
            index_q <= index_q + IDX_W'(1);
          end
        end
        default: begin
          index_q <= {IDX_W{1'b0}};
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  // Lane-count register: capture requests, apply only between words
  // (idle, or the very edge at which the current word finishes).
  always_ff @(posedge clk) begin
    if (rst) begin
      fw_q         <= FW_FULL;
      pending_q    <= 1'b0;
      pending_fw_q <= FW_FULL;
    end else if (apply_s) begin
      fw_q         <= req_fw_s;
      pending_q    <= 1'b0;
      pending_fw_q <= req_fw_s;
    end else if (change_fetch_width) begin
      pending_q    <= 1'b1;
      pending_fw_q <= change_fw_s;
    end
  end

endmodule

// File: doc/disaggregator.md
DISAGGREGATOR -- requirements
Module: disaggregator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: narrow word width in bits.
REQ-002 SHALL have parameter FETCH_WIDTH, default 2: max narrow lanes per wide word; legal range 2..16.
REQ-003 SHALL have port clk  input  1: single clock; every register samples on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous active-high reset.
REQ-005 SHALL have port sender_data  input  FETCH_WIDTH*DATA_WIDTH: wide word, first-word-fall-through; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-006 SHALL have port sender_empty_n  input  1: sender_data valid.
REQ-007 SHALL have port sender_deq  output  1: pop the sender this cycle.
REQ-008 SHALL have port receiver_data  output  DATA_WIDTH: current narrow word.
REQ-009 SHALL have port receiver_full_n  input  1: receiver can accept.
REQ-010 SHALL have port receiver_enq  output  1: receiver_data is written this cycle.
REQ-011 SHALL have port change_fetch_width  input  1: one-cycle request to load a new lane count.
REQ-012 SHALL have port input_fetch_width  input  $clog2(FETCH_WIDTH)+1: requested lane count.
REQ-013 SHALL have port busy  output  1: holding register non-empty or width change pending.

Function
- REQ-014 SHALL hold one wide word in a holding register plus a lane index (0..FETCH_WIDTH-1) and a valid flag; states EMPTY (valid=0) and EMIT (valid=1).
- REQ-015 SHALL emit lanes in ascending order, lane 0 (LSBs) first, lanes 0..fw-1 only, where fw is the active width; lanes >= fw are discarded.
- REQ-016 SHALL drive receiver_data = holding lane[index] combinationally; receiver_enq = valid && receiver_full_n.
- REQ-017 SHALL advance the index on each receiver_enq; on enq of lane fw-1, index returns to 0 and valid clears, unless reloaded the same cycle.
- REQ-018 SHALL assert sender_deq = sender_empty_n && !pending_change && (!valid || (receiver_enq && index==fw-1)); on sender_deq the holding register loads sender_data, index=0, valid=1.
- REQ-019 Latency: word popped at edge N presents lane 0 on receiver_data in cycle N+1; with receiver_full_n and sender_empty_n held high, output SHALL be one narrow word every cycle with no bubble between wide words.
- REQ-020 receiver_full_n low SHALL freeze index, valid and receiver_data; no lane is lost or duplicated.
- REQ-021 sender_empty_n low at a word boundary SHALL return the block to EMPTY with receiver_enq=0.
- REQ-022 change_fetch_width SHALL set pending_change with the captured value; it SHALL apply to fw only when valid=0 (including the cycle valid clears), and no deq occurs while pending; a new request while pending overwrites the captured value.
- REQ-023 input_fetch_width values 0 or > FETCH_WIDTH SHALL clamp to FETCH_WIDTH.
- REQ-024 change_fetch_width asserted in the same cycle as the final-lane enq SHALL apply before the next word is loaded (next deq one cycle later).

Reset
- REQ-025 On rst: valid=0, index=0, fw=FETCH_WIDTH, pending_change=0; hence receiver_enq=0, sender_deq=0, busy=0 in the cycle after reset; receiver_data is don't-care.
- REQ-026 Reset mid-word SHALL discard remaining lanes; sender_deq SHALL be 0 while rst is high.

Structure
- REQ-027 Lane-index width and the clamp function SHALL live in the shared stream package used by the aggregator; DATA_WIDTH/FETCH_WIDTH remain module parameters.
- REQ-028 No sub-module is required; the lane mux SHALL be a single indexed part-select.

Verification
- REQ-029 FETCH_WIDTH=2, FIFO holding 0x0100, 0x0302, both handshakes high -> receiver sees 00,01,02,03 on four consecutive cycles; sender_deq pulses on cycles 0 and 2.
- REQ-030 Same data, receiver_full_n toggled randomly -> output sequence still 00,01,02,03, no gaps in values, each value enq'd exactly once.
- REQ-031 FETCH_WIDTH=4, change_fetch_width with value 2 while idle, word 0x33221100 -> receiver sees 00,11 only; next word lane 0 follows immediately.
- REQ-032 Width change to 3 asserted mid-word (FETCH_WIDTH=4) -> current word emits all 4 lanes, next word emits 3.
- REQ-033 rst pulsed after lane 0 of 0x0302 -> lane 03 never emitted; after release next FIFO word starts at its lane 0, fw=FETCH_WIDTH.
- REQ-034 Loop-back: aggregator -> disaggregator with random stall on both sides, 200 words -> output equals input stream in order.
